// File: rtl/fft_pkg.sv
// Shared FFT front-end definitions: default frame geometry and loader states.
package fft_pkg;

  localparam int unsigned DEF_NUM_SAMPLES = 512;
  localparam int unsigned DEF_SAMP_W      = 16;
  localparam int unsigned DEF_ADDR_W      = 64;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/flex_counter.sv
// Generic up-counter with synchronous clear and programmable rollover value.
module flex_counter #(
  parameter int unsigned NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] count_nxt;

  // Next count: clear wins, otherwise wrap to zero after rollover_val.
  always_comb begin
    count_nxt = count_out;
    if (clear) begin
      count_nxt = '0;
    end else if (count_enable) begin
      if (count_out == rollover_val) begin
        count_nxt = '0;
      end else begin
        count_nxt = count_out + NUM_CNT_BITS'(1);
      end
    end
  end

  // Count register; flag is registered so it tracks count_out exactly.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count_out     <= '0;
      rollover_flag <= 1'b0;
    end else begin
      count_out     <= count_nxt;
      rollover_flag <= (count_nxt == rollover_val);
    end
  end

endmodule

// File: rtl/avalon_sample_loader.sv
// Avalon-MM pipelined read master loading one frame of samples into the FFT
// input buffer. Optional watchdog/ERR state enabled by macro LOAD_TIMEOUT_EN.
module avalon_sample_loader
  import fft_pkg::*;
#(
  parameter int unsigned NUM_SAMPLES = DEF_NUM_SAMPLES,
  parameter int unsigned SAMP_W      = DEF_SAMP_W,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned MAX_PENDING = 4,
  localparam int unsigned IDX_W      = $clog2(NUM_SAMPLES)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              rEn,
  output logic [ADDR_W-1:0] address,
  input  logic              waitrequest,
  input  logic [SAMP_W-1:0] rData,
  input  logic              readdatavalid,
  output logic              buf_wEn,
  output logic [IDX_W-1:0]  buf_addr,
  output logic [SAMP_W-1:0] buf_wData,
  output logic              busy,
  output logic              load_done,
  output logic              err
);

  localparam logic [IDX_W:0]   FRAME_LEN = (IDX_W+1)'(NUM_SAMPLES);
  localparam logic [IDX_W:0]   PEND_MAX  = (IDX_W+1)'(MAX_PENDING);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_SAMPLES - 1);

  loader_state_t     state;
  logic [IDX_W:0]    issue_cnt;
  logic [IDX_W:0]    issue_nxt;
  logic [IDX_W:0]    ret_cnt;
  logic [IDX_W:0]    ret_nxt;
  logic [IDX_W:0]    pend_nxt;
  logic [IDX_W-1:0]  ret_low;
  logic              ret_wrap;
  logic              ret_full;
  logic [ADDR_W-1:0] cur_addr;
  logic              start_acc;
  logic              in_xfer;
  logic              accept;
  logic              ret_ok;

  // Transfer qualifiers and next-cycle counter views used for rEn lookahead.
  assign start_acc = (state == IDLE) && start;
  assign in_xfer   = (state == ISSUE) || (state == DRAIN);
  assign accept    = rEn && !waitrequest;
  assign ret_ok    = readdatavalid && in_xfer && !ret_full;
  assign ret_cnt   = {ret_full, ret_low};
  assign issue_nxt = issue_cnt + (IDX_W+1)'(accept);
  assign ret_nxt   = ret_cnt + (IDX_W+1)'(ret_ok);
  assign pend_nxt  = issue_nxt - ret_nxt;
  assign address   = cur_addr;

  // Return counter: low bits wrap after the last index, ret_full supplies the MSB.
  flex_counter #(
    .NUM_CNT_BITS(IDX_W)
  ) u_ret_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (start_acc),
    .count_enable (ret_ok),
    .rollover_val (LAST_IDX),
    .count_out    (ret_low),
    .rollover_flag(ret_wrap)
  );

`ifdef LOAD_TIMEOUT_EN
  localparam logic [9:0] WD_LAST = 10'd1022;

  logic [IDX_W:0] pend;
  logic [9:0]     wd_cnt;
  logic           stall;
  logic           progress;
  logic           wd_trip;

  assign pend     = issue_cnt - ret_cnt;
  assign stall    = ((pend != '0) && !readdatavalid) || (rEn && waitrequest);
  assign progress = accept || ret_ok;
  assign wd_trip  = in_xfer && !progress && stall && (wd_cnt == WD_LAST);

  // Watchdog: counts stalled cycles, trips on the 1023rd consecutive one.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      err <= wd_trip;
      if (!in_xfer || progress) begin
        wd_cnt <= '0;
      end else if (stall) begin
        wd_cnt <= wd_cnt + 10'd1;
      end
    end
  end
`else
  assign err = 1'b0;
`endif

  // Loader FSM with registered Avalon and buffer-side outputs.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state     <= IDLE;
      issue_cnt <= '0;
      ret_full  <= 1'b0;
      cur_addr  <= '0;
      rEn       <= 1'b0;
      buf_wEn   <= 1'b0;
      buf_addr  <= '0;
      buf_wData <= '0;
      busy      <= 1'b0;
      load_done <= 1'b0;
    end else begin
      buf_wEn   <= ret_ok;
      load_done <= 1'b0;
      if (ret_ok) begin
        buf_wData <= rData;
        buf_addr  <= ret_low;
      end
      if (ret_ok && ret_wrap) begin
        ret_full <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            issue_cnt <= '0;
            ret_full  <= 1'b0;
            cur_addr  <= {base_addr[ADDR_W-1:1], 1'b0};
            rEn       <= 1'b1;
          end
        end
        ISSUE: begin
          issue_cnt <= issue_nxt;
          if (accept) begin
            cur_addr <= cur_addr + ADDR_W'(2);
          end
          if (issue_nxt == FRAME_LEN) begin
            state <= DRAIN;
            rEn   <= 1'b0;
          end else begin
            rEn <= (pend_nxt < PEND_MAX);
          end
        end
        DRAIN: begin
          rEn <= 1'b0;
          if (ret_full) begin
            state     <= DONE;
            load_done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        ERR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          rEn   <= 1'b0;
        end
      endcase
`ifdef LOAD_TIMEOUT_EN
      if (wd_trip) begin
        state <= ERR;
        rEn   <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: doc/avalon_sample_loader.md
Name: avalon_sample_loader

Overview:
Avalon-MM pipelined read master that fetches one frame of 512 16-bit time-domain samples from system memory into the FFT input sample buffer. On completion it pulses load_done, which starts the FFT core. It is the input-side counterpart of the Avalon write master that drains FFT results after fft_done. It shares that block's address/data widths and its rEn/address/rData naming.

Parameters:
NUM_SAMPLES, 512, samples per frame; power of two; buffer index width IDX_W = log2(NUM_SAMPLES) = 9
SAMP_W, 16, sample width in bits
ADDR_W, 64, Avalon byte-address width
MAX_PENDING, 4, maximum outstanding read requests (1..8)

Ports:
clk  in  1  system clock
n_rst  in  1  reset, synchronous, active-low
start  in  1  one-cycle request to load a frame; honoured only in IDLE
base_addr  in  ADDR_W  byte address of sample 0; captured on accepted start
rEn  out  1  Avalon read request
address  out  ADDR_W  Avalon byte address
waitrequest  in  1  Avalon slave stall
rData  in  SAMP_W  Avalon read data
readdatavalid  in  1  rData valid this cycle
buf_wEn  out  1  sample buffer write enable
buf_addr  out  IDX_W  sample buffer write index
buf_wData  out  SAMP_W  sample buffer write data
busy  out  1  high in every state except IDLE
load_done  out  1  one-cycle pulse when the frame is fully written
err  out  1  one-cycle timeout pulse; only with LOAD_TIMEOUT_EN

Behaviour:
- Reset, sampled on clk while n_rst=0: state=IDLE, all counters 0, and rEn, address, buf_wEn, buf_addr, buf_wData, busy, load_done and err all 0. A reset mid-frame abandons the frame with no load_done; readdatavalid beats still in flight after reset are ignored.
- Registers: issue_cnt (IDX_W+1 bits), ret_cnt (IDX_W+1 bits), pend = issue_cnt - ret_cnt (IDX_W+1 bits), cur_addr (ADDR_W bits).
- IDLE -> ISSUE on start=1. On that edge: base_addr captured with bit 0 forced to 0, and both counters cleared.
- ISSUE:
  - rEn = (issue_cnt < NUM_SAMPLES) and (pend < MAX_PENDING); address = cur_addr.
  - A request is accepted on a cycle with rEn=1 and waitrequest=0; on acceptance issue_cnt+1 and cur_addr+2.
  - While waitrequest=1, rEn and address stay stable.
  - ISSUE -> DRAIN once issue_cnt = NUM_SAMPLES.
- Data return, in ISSUE and DRAIN:
  - Each readdatavalid=1 registers buf_wData=rData and buf_addr=ret_cnt[IDX_W-1:0], with buf_wEn=1 on the next cycle (latency 1); ret_cnt+1.
  - Acceptance and return in the same cycle update both counters; pend changes by 0.
- DRAIN: rEn=0. DRAIN -> DONE when ret_cnt = NUM_SAMPLES and the final buf_wEn has been issued.
- DONE: load_done=1 for exactly one cycle, then IDLE. Data order in the buffer equals request order (Avalon returns in order).
- readdatavalid in IDLE or DONE is ignored. Any readdatavalid beyond NUM_SAMPLES is ignored.
- start while busy is ignored. start in DONE is ignored.
- address wrap at 2^ADDR_W: natural modulo, no error.

Optional Feature:
LOAD_TIMEOUT_EN:
- Defined:
  - A 10-bit watchdog counts cycles with pend>0 and no readdatavalid, or with rEn=1 and waitrequest=1.
  - The watchdog clears on any progress.
  - Reaching 1023 enters state ERR. ERR pulses err for one cycle, with rEn=0 and no load_done, then IDLE.
- Undefined: no watchdog and no ERR state; err is tied to 0.

Decomposition:
- Shared package fft_pkg:
  - NUM_SAMPLES, SAMP_W and ADDR_W defaults
  - the loader state enum (IDLE, ISSUE, DRAIN, DONE, ERR)
- Sub-module: reuse the existing flex_counter for ret_cnt (rollover at NUM_SAMPLES-1, rollover_flag used for DRAIN exit). Issue logic stays inline.

Test Plan:
1. Zero-wait slave with 2-cycle read latency; start with base_addr=0x1000:
   - 512 accepted requests at addresses 0x1000 to 0x13FE
   - buffer[i] = slave word i
   - load_done exactly once, about 515 cycles after start
2. waitrequest held high 5 cycles on every 3rd request -> address stable while stalled, no duplicate or skipped addresses, final buffer correct.
3. Slave latency 10 cycles, MAX_PENDING=4 -> pend never exceeds 4, rEn drops while pend=4, all 512 samples correct.
4. start pulsed again mid-frame, then base_addr=0x1001 on a fresh frame:
   - the second start is ignored
   - the next frame issues to 0x1000 (bit 0 cleared)
5. n_rst=0 for 1 cycle at sample 200 -> all outputs 0 next cycle, no load_done, late readdatavalid ignored, new start loads a clean frame.
6. LOAD_TIMEOUT_EN defined, slave never returns data after 3 requests -> err pulses at 1023 stall cycles, state returns to IDLE, busy=0.
